// File: rtl/int_generator_pkg.sv
// Shared definitions for the interrupt-generator peripheral.
//   - FSM state encoding for int_generator
//   - trigger table depth and index width
//   - peripheral word-address map (interrupt acknowledge plus neighbours)
//   - word_addr(): drops the byte-offset bits of a 32-bit byte address
package int_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ASSERT = 2'd2
  } int_state_e;

  localparam int TABLE_DEPTH = 4;
  localparam int TABLE_IDX_W = 2;

  // Peripheral address map (byte addresses, word aligned).
  localparam logic [31:0] TIMER_BASE_ADDR  = 32'h0000_7F00;
  localparam logic [31:0] UART_BASE_ADDR   = 32'h0000_7F10;
  localparam logic [31:0] INT_ADDR_DEFAULT = 32'h0000_7F20;

  function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/int_trigger_table.sv
// Trigger table: TABLE_DEPTH entries of {word PC, valid}.
// Ports:
//   clk, reset       clock and synchronous active-high reset (clears valid bits)
//   cfg_we/idx/pc    table write; the written entry becomes valid next cycle
//   pc               CPU architectural PC compared against every valid entry
//   match_en         high when the caller can accept a trigger this cycle
//   fire             a trigger is accepted this cycle (entry is consumed)
//   fire_idx         index of the consumed entry (lowest matching index)
module int_trigger_table
  import int_generator_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [TABLE_IDX_W-1:0] cfg_idx,
  input  logic [31:0]            cfg_pc,
  input  logic [31:0]            pc,
  input  logic                   match_en,
  output logic                   fire,
  output logic [TABLE_IDX_W-1:0] fire_idx
);

  logic [29:0]            entry_pc_q [TABLE_DEPTH];
  logic [TABLE_DEPTH-1:0] valid_q;
  logic [TABLE_DEPTH-1:0] valid_d;
  logic [TABLE_DEPTH-1:0] match_vec;
  logic                   hit;

  // An entry being rewritten this cycle is excluded from matching, so the
  // write wins and the old PC can never trigger.
  generate
    for (genvar gi = 0; gi < TABLE_DEPTH; gi++) begin : g_cmp
      assign match_vec[gi] = valid_q[gi]
                          && (entry_pc_q[gi] == word_addr(pc))
                          && !(cfg_we && (cfg_idx == TABLE_IDX_W'(gi)));
    end
  endgenerate

  // Lowest index wins: scan downward so the last assignment is the lowest.
  always_comb begin
    hit      = 1'b0;
    fire_idx = '0;
    for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        hit      = 1'b1;
        fire_idx = TABLE_IDX_W'(i);
      end
    end
  end

  assign fire = hit && match_en;

  always_comb begin
    valid_d = valid_q;
    if (fire)   valid_d[fire_idx] = 1'b0;
    if (cfg_we) valid_d[cfg_idx]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // PC storage needs no reset: an entry is only looked at while valid.
  always_ff @(posedge clk) begin
    if (cfg_we && !reset) entry_pc_q[cfg_idx] <= word_addr(cfg_pc);
  end

endmodule

// File: rtl/int_generator.sv
// Interrupt generator: when the CPU PC hits a programmed trigger, waits
// DELAY cycles, raises interrupt and holds it until the CPU writes INT_ADDR.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   macroscopic_pc    CPU architectural PC
//   m_int_addr/byteen CPU write toward this block (ack = write to INT_ADDR)
//   cfg_we/idx/pc     trigger table programming
//   interrupt         registered interrupt line, high exactly in ASSERT
//   busy              high whenever not IDLE
//   ack_err           sticky: ack timeout or spurious ack
//   fired_cnt         completed handshake count (wraps)
module int_generator
  import int_generator_pkg::*;
#(
  parameter logic [31:0] INT_ADDR    = INT_ADDR_DEFAULT,
  parameter int          DELAY       = 4,
  parameter int          ACK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] macroscopic_pc,
  input  logic [31:0] m_int_addr,
  input  logic [3:0]  m_int_byteen,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_idx,
  input  logic [31:0] cfg_pc,
  output logic        interrupt,
  output logic        busy,
  output logic        ack_err,
  output logic [7:0]  fired_cnt
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  int_state_e          state_q, state_d;
  logic [7:0]          dly_cnt_q, dly_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                interrupt_q;
  logic                ack_err_q, ack_err_d;
  logic [7:0]          fired_q, fired_d;
  logic                ack;
  logic                fire;
  logic [TABLE_IDX_W-1:0] fire_idx;

  assign ack = (word_addr(m_int_addr) == word_addr(INT_ADDR)) && (m_int_byteen != 4'b0000);

  int_trigger_table u_table (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_pc   (cfg_pc),
    .pc       (macroscopic_pc),
    .match_en (state_q == ST_IDLE),
    .fire     (fire),
    .fire_idx (fire_idx)
  );

  always_comb begin
    state_d   = state_q;
    dly_cnt_d = dly_cnt_q;
    to_cnt_d  = to_cnt_q;
    ack_err_d = ack_err_q;
    fired_d   = fired_q;
    case (state_q)
      ST_IDLE: begin
        if (ack) ack_err_d = 1'b1;
        if (fire) begin
          state_d   = ST_DELAY;
          dly_cnt_d = 8'(DELAY);
        end
      end
      ST_DELAY: begin
        if (ack) ack_err_d = 1'b1;
        if (dly_cnt_q == 8'd0) begin
          state_d  = ST_ASSERT;
          to_cnt_d = '0;
        end else begin
          dly_cnt_d = dly_cnt_q - 8'd1;
        end
      end
      ST_ASSERT: begin
        if (ack) begin
          state_d  = ST_IDLE;
          fired_d  = fired_q + 8'd1;
          to_cnt_d = '0;
        end else begin
          // to_cnt_q counts completed ASSERT cycles before this one; the
          // flag sets at the end of the ACK_TIMEOUT-th cycle. Saturates.
          if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) ack_err_d = 1'b1;
          if (to_cnt_q != TO_W'(ACK_TIMEOUT))     to_cnt_d  = to_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dly_cnt_q   <= '0;
      to_cnt_q    <= '0;
      interrupt_q <= 1'b0;
      ack_err_q   <= 1'b0;
      fired_q     <= '0;
    end else begin
      state_q     <= state_d;
      dly_cnt_q   <= dly_cnt_d;
      to_cnt_q    <= to_cnt_d;
      interrupt_q <= (state_d == ST_ASSERT);
      ack_err_q   <= ack_err_d;
      fired_q     <= fired_d;
    end
  end

  assign interrupt = interrupt_q;
  assign busy      = (state_q != ST_IDLE);
  assign ack_err   = ack_err_q;
  assign fired_cnt = fired_q;

endmodule
